// File: rtl/raybox_pkg.sv
// Shared constants for the raybox input path: button bit mapping and debounce defaults.
package raybox_pkg;

    localparam int N_BUTTONS = 5;

    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_F   = 2;
    localparam int BTN_B   = 3;
    localparam int BTN_MAP = 4;

    // 25000 cycles of the 25 MHz pixel clock is a 1 ms sample tick.
    localparam int TICK_DIV_DEF     = 25000;
    localparam int STABLE_TICKS_DEF = 8;

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_HELD     = 1'b1
    } btn_state_e;

endpackage

// File: rtl/raybox_buttons_debounce_bit.sv
// Single-line conditioner: 2-flop synchroniser, tick-driven stability counter and level register.
// BUTTON_PRESS_PULSE_EN adds a registered one-cycle pulse on each accepted press.
module debounce_bit
    import raybox_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_n_i,
    output logic btn_o
`ifdef BUTTON_PRESS_PULSE_EN
    ,
    output logic press_o
`endif
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic            s1_q;
    logic            s2_q;
    logic            sync;
    logic [CW-1:0]   cnt_q;
    btn_state_e      state_q;
`ifdef BUTTON_PRESS_PULSE_EN
    logic            press_q;
`endif

    assign sync  = ~s2_q;
    assign btn_o = (state_q == BTN_HELD);
`ifdef BUTTON_PRESS_PULSE_EN
    assign press_o = press_q;
`endif

    // Synchroniser resets to the released level so reset cannot fake a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= BTN_RELEASED;
`ifdef BUTTON_PRESS_PULSE_EN
            press_q <= 1'b0;
`endif
        end else begin
            s1_q <= btn_n_i;
            s2_q <= s1_q;
`ifdef BUTTON_PRESS_PULSE_EN
            press_q <= 1'b0;
`endif
            if (tick_i) begin
                if (sync == (state_q == BTN_HELD)) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    case (state_q)
                        BTN_RELEASED: begin
                            state_q <= BTN_HELD;
`ifdef BUTTON_PRESS_PULSE_EN
                            press_q <= 1'b1;
`endif
                        end
                        default: state_q <= BTN_RELEASED;
                    endcase
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/raybox_buttons.sv
// Button conditioner feeding raybox: shared sample-tick prescaler plus one debouncer per line.
// BUTTON_PRESS_PULSE_EN exposes btn_press (one-clk pulse per accepted press).
module raybox_buttons
    import raybox_pkg::*;
#(
    parameter int N_BUTTONS    = raybox_pkg::N_BUTTONS,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn_n,
    output logic [N_BUTTONS-1:0] btn,
    output logic                 tick
`ifdef BUTTON_PRESS_PULSE_EN
    ,
    output logic [N_BUTTONS-1:0] btn_press
`endif
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (tick),
            .btn_n_i (btn_n[i]),
            .btn_o   (btn[i])
`ifdef BUTTON_PRESS_PULSE_EN
            ,
            .press_o (btn_press[i])
`endif
        );
    end

endmodule

// File: tb/tb_raybox_buttons.sv
// Self-checking bench for raybox_buttons with TICK_DIV=4, STABLE_TICKS=3.
// Checks btn_press as well when BUTTON_PRESS_PULSE_EN is defined.
module tb_raybox_buttons;

    localparam int NB = 5;
    localparam int TD = 4;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_n = '1;
    logic [NB-1:0] btn;
    logic          tick;
`ifdef BUTTON_PRESS_PULSE_EN
    logic [NB-1:0] btn_press;
`endif

    always #5 clk = ~clk;

    raybox_buttons #(
        .N_BUTTONS   (NB),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_n     (btn_n),
        .btn       (btn),
        .tick      (tick)
`ifdef BUTTON_PRESS_PULSE_EN
        ,
        .btn_press (btn_press)
`endif
    );

    typedef struct {
        logic [NB-1:0] btn_n;
        int            hold;
        logic [NB-1:0] exp_btn;
    } vec_t;

    vec_t          vecs[$];
    logic [NB-1:0] sb_q[$];

    int            n_vec = 0;
    int            n_err = 0;
    int            rise_cnt[NB];
    int            press_cnt[NB];
    logic [NB-1:0] prev_btn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d cycles expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) begin
            rise_cnt[i]  = 0;
            press_cnt[i] = 0;
        end
        prev_btn = btn;
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) begin
            rise_cnt[i] += int'(btn[i] & ~prev_btn[i]);
`ifdef BUTTON_PRESS_PULSE_EN
            press_cnt[i] += int'(btn_press[i]);
`endif
        end
        prev_btn = btn;
    endtask

    // Leaves the bench in the first cycle after reset release (prescaler at 0).
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic wait_change(input logic [NB-1:0] mask, input int maxc, output int k);
        logic [NB-1:0] start;
        start = btn & mask;
        k = 0;
        while (((btn & mask) === start) && k < maxc) begin
            step();
            k++;
        end
    endtask

    initial begin
        int k;
        logic seen;

        // Reset state and tick cadence
        btn_n = '1;
        do_reset(3);
        check("rst_btn", btn, 0);
`ifdef BUTTON_PRESS_PULSE_EN
        check("rst_press", btn_press, 0);
`endif
        for (int c = 0; c < 16; c++) begin
            if (c > 0) step();
            check($sformatf("tick_c%0d", c), tick, (c % TD) == TD - 1);
        end

        // Table vectors: long holds settle, short holds are glitches
        vecs.push_back('{5'b11110, 16, 5'b00001});
        vecs.push_back('{5'b11100, 16, 5'b00011});
        vecs.push_back('{5'b11110,  5, 5'b00011});
        vecs.push_back('{5'b00000, 16, 5'b11111});
        vecs.push_back('{5'b11111, 16, 5'b00000});
        vecs.push_back('{5'b01010, 16, 5'b10101});
        vecs.push_back('{5'b10101, 16, 5'b01010});
        vecs.push_back('{5'b10100,  8, 5'b01010});
        vecs.push_back('{5'b10101, 16, 5'b01010});
        vecs.push_back('{5'b11111, 16, 5'b00000});
        do_reset(2);
        for (int v = 0; v < vecs.size(); v++) begin
            btn_n = vecs[v].btn_n;
            sb_q.push_back(vecs[v].exp_btn);
            repeat (vecs[v].hold) step();
            check($sformatf("vec%0d", v), btn, sb_q.pop_front());
        end

        // Clean press on bit 2
        btn_n = '1;
        do_reset(2);
        btn_n[2] = 1'b0;
        wait_change(5'b00100, 40, k);
        check_win("press_latency", k, 11, 14);
        repeat (10) step();
        check("press_level", btn, 5'b00100);
        check("press_rises", rise_cnt[2], 1);
`ifdef BUTTON_PRESS_PULSE_EN
        check("press_pulse", press_cnt[2], 1);
`endif

        // Glitch rejection on bit 0
        btn_n = '1;
        do_reset(2);
        btn_n[0] = 1'b0;
        repeat (5) step();
        btn_n[0] = 1'b1;
        seen = 1'b0;
        repeat (45) begin
            step();
            seen |= btn[0];
        end
        check("glitch_level", seen, 0);
        check("glitch_rises", rise_cnt[0], 0);

        // Bounce then settle on bit 1
        btn_n = '1;
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            btn_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) step();
        end
        btn_n[1] = 1'b0;
        k = 0;
        while (btn[1] !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check_win("bounce_settle", k, 0, 14);
        repeat (20) step();
        check("bounce_rises", rise_cnt[1], 1);
`ifdef BUTTON_PRESS_PULSE_EN
        check("bounce_pulse", press_cnt[1], 1);
`endif

        // Simultaneous press and release on bits 3 and 4
        btn_n = '1;
        do_reset(2);
        btn_n[4:3] = 2'b00;
        wait_change(5'b11000, 40, k);
        check_win("sim_press_lat", k, 11, 14);
        check("sim_press_pair", btn, 5'b11000);
        repeat (4) step();
        clear_counts();
        btn_n[4:3] = 2'b11;
        wait_change(5'b11000, 40, k);
        check_win("sim_rel_lat", k, 11, 14);
        check("sim_rel_pair", btn, 5'b00000);
`ifdef BUTTON_PRESS_PULSE_EN
        repeat (4) step();
        check("sim_rel_nopulse", press_cnt[3] + press_cnt[4], 0);
`endif

        // Reset while bit 2 is held
        btn_n = '1;
        do_reset(2);
        btn_n[2] = 1'b0;
        wait_change(5'b00100, 40, k);
        check("mid_pre", btn[2], 1);
        reset = 1'b1;
        step();
        check("mid_rst_btn", btn[2], 0);
`ifdef BUTTON_PRESS_PULSE_EN
        check("mid_rst_press", btn_press, 0);
`endif
        reset = 1'b0;
        clear_counts();
        wait_change(5'b00100, 40, k);
        check_win("mid_reaccept", k, 11, 14);
        repeat (10) step();
        check("mid_level", btn[2], 1);
        check("mid_rises", rise_cnt[2], 1);
`ifdef BUTTON_PRESS_PULSE_EN
        check("mid_pulse", press_cnt[2], 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/raybox_buttons.md
# raybox_buttons

Input conditioner that sits directly upstream of the raybox core. It takes the raw, active-low, asynchronous pushbutton lines (external K1..K4 movement buttons and the onboard map button), synchronises and debounces them, and drives clean active-high levels onto raybox's moveL/moveR/moveF/moveB/show_map inputs. Optional one-cycle press pulses are provided for future edge-triggered controls.

## Interface
Parameters:
- N_BUTTONS, 5: number of button lines. Bit mapping is in the package.
- TICK_DIV, 25000: clk cycles per debounce sample tick. At 25 MHz this is 1 ms. Must be ≥2.
- STABLE_TICKS, 8: consecutive disagreeing samples required to accept a new level. Must be ≥1.

Ports:
- clk  in  1  pixel clock, 25 MHz; the same clock as raybox.
- reset  in  1  synchronous, active-high reset.
- btn_n  in  N_BUTTONS  raw button lines, active-low, asynchronous to clk.
- btn  out  N_BUTTONS  debounced level, active-high (1 = held).
- btn_press  out  N_BUTTONS  one-clk pulse on each accepted press. Present only with the macro enabled.
- tick  out  1  sample-tick strobe, exported for debug and LED visualisation.

## Operation
- Synchroniser:
  - Each bit passes through two flops.
  - The second stage is inverted to give the active-high `sync[i]`.
  - Both flop stages reset to 1 (released), so reset never creates a phantom press.
- Prescaler:
  - `presc` counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` = (presc == TICK_DIV-1), combinational from the register.
  - Width is $clog2(TICK_DIV).
- Per-bit debounce, evaluated only on cycles where tick=1:
  - If sync[i] == btn[i]: cnt[i] <= 0.
  - Else, if cnt[i] == STABLE_TICKS-1: btn[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - When tick=0, cnt and btn hold.
  - cnt width is $clog2(STABLE_TICKS+1). The counter never exceeds STABLE_TICKS-1.
- Two-state view per bit: RELEASED (btn=0) and HELD (btn=1). Each transition requires STABLE_TICKS consecutive disagreeing ticks.
  - Any agreeing tick restarts the count, so a bounce shorter than that run is rejected.
- Simultaneous events:
  - Bits are fully independent; several bits may change on the same tick.
  - A pending count on one bit is unaffected by activity on others.
- btn_press[i] is asserted for exactly the cycle after the clk edge on which btn[i] goes 0→1. Release generates nothing.
- Reset mid-operation:
  - Next edge: btn=0, btn_press=0, all cnt=0, presc=0, sync flops=1.
  - A button still held after reset is re-accepted through the normal STABLE_TICKS path.

## Timing
- Reset values: btn=0, btn_press=0, tick=0. presc=0, so the first tick occurs TICK_DIV-1 cycles after reset deasserts.
- tick period: exactly TICK_DIV clk cycles, high for 1 cycle.
- Synchroniser latency: 2 cycles from raw edge to sync.
- Press/release latency: from raw edge to btn change, between 2+(STABLE_TICKS-1)·TICK_DIV+1 and 2+STABLE_TICKS·TICK_DIV cycles.
- btn and btn_press are registered outputs. There are no combinational paths from btn_n.

## Configuration
- BUTTON_PRESS_PULSE_EN:
  - Defined: the btn_press port and its edge-detect logic exist, registered as `btn & ~btn_q`.
  - Undefined: the btn_press port is absent, and btn and tick behave identically to the defined build.

## Structure
- Shared package raybox_pkg holds:
  - N_BUTTONS = 5.
  - Index constants BTN_L=0, BTN_R=1, BTN_F=2, BTN_B=3, BTN_MAP=4.
  - Default TICK_DIV and STABLE_TICKS.
- One natural sub-module, `debounce_bit`: synchroniser, counter and level register for a single line.
  - Generate-instantiated N_BUTTONS times.
  - Shares the single prescaler tick held in the top level.

## Test plan
All scenarios use TICK_DIV=4 and STABLE_TICKS=3.
- Reset: hold reset for 3 cycles with btn_n=5'b11111 → btn=0, btn_press=0. tick first high at cycle 3 after release, then every 4 cycles.
- Clean press: drive btn_n[2]=0 at cycle 0 and hold → btn[2] rises in the window of cycles 11..14. btn_press[2] is high for exactly 1 cycle. All other btn bits stay 0.
- Glitch rejection: btn_n[0]=0 for 5 cycles, then 1 → btn[0] stays 0 for the following 40 cycles.
- Bounce then settle: toggle btn_n[1] every 2 cycles for 20 cycles, then hold low → exactly one btn_press[1] pulse. btn[1]=1 within 14 cycles of the final settle.
- Release and simultaneous bits: hold btn_n[3] and btn_n[4] low until both btn=1, then release both on the same cycle → both btn bits fall on the same edge, 11..14 cycles later, with no btn_press.
- Mid-operation reset: assert reset while btn[2]=1 and btn_n[2] is still 0 → btn[2]=0 on the next edge. After release, btn[2] re-asserts within 14 cycles with one btn_press[2].
